// File: rtl/rs232_pkg.sv
// Purpose: shared RS232 definitions (state encoding, data width, default bit period) for TX and RX.
// Latency: n/a, declarations only.
// Backpressure: n/a.
package rs232_pkg;

   localparam int DATA_BITS           = 8;
   localparam int DEFAULT_CLK_DIVIDER = 5208;   // 9600 baud at 50 MHz

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/baud_tick.sv
// Purpose: bit-period timer, counts 0..CLK_DIVIDER-1 and flags the last cycle of each bit.
// Latency: tick is combinational from the count register; clear takes effect on the next edge.
// Backpressure: none; free-running unless clear is held.
// Ports: clk, rst (async active-high), clear (hold count at 0),
//        tick (count == CLK_DIVIDER-1), count (current position inside the bit).
module baud_tick
   import rs232_pkg::*;
#(
   parameter int CLK_DIVIDER = DEFAULT_CLK_DIVIDER
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   output logic        tick,
   output logic [15:0] count
);

   localparam logic [15:0] LAST = 16'(CLK_DIVIDER - 1);

   logic [15:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clear || tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 16'd1;
      end
   end

   assign tick  = (r_count == LAST);
   assign count = r_count;

endmodule

// File: rtl/rs232_transmitter.sv
// Purpose: 8N1 UART transmitter with a one-byte holding register for gap-free back-to-back frames.
// Latency: byte accepted at edge N, start bit on the line after edge N+1; frame lasts 10*CLK_DIVIDER cycles.
// Backpressure: data_ready low while the holding register is full; it is a flop, never combinational from data_valid.
// Ports: clk, rst (async active-high), data_in/data_valid/data_ready (byte handshake),
//        tx (serial line, idle high), busy (frame in progress), tx_done (last cycle of stop bit).
module rs232_transmitter
   import rs232_pkg::*;
#(
   parameter int CLK_DIVIDER = DEFAULT_CLK_DIVIDER
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   // tx_done is registered, so it is armed one cycle before the stop bit ends.
   localparam logic [15:0] PRE_LAST = 16'(CLK_DIVIDER - 2);
   localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

   tx_state_t            r_state;
   logic [DATA_BITS-1:0] r_hold;
   logic                 r_hold_full;
   logic [DATA_BITS-1:0] r_shift;
   logic [2:0]           r_bit_idx;
   logic                 r_tx;
   logic                 r_busy;
   logic                 r_tx_done;

   logic                 w_clear;
   logic                 w_tick;
   logic [15:0]          w_count;
   logic                 w_load;

   // Timer parked at 0 while idle so the start bit gets a full period.
   assign w_clear = (r_state == ST_IDLE);

   baud_tick #(.CLK_DIVIDER(CLK_DIVIDER)) u_baud_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (w_clear),
      .tick  (w_tick),
      .count (w_count)
   );

   // The held byte moves to the shifter from IDLE or at the very end of STOP.
   assign w_load = r_hold_full &&
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_tick));

   // Holding register; a load and a write never coincide because data_ready is low while full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else if (w_load) begin
         r_hold_full <= 1'b0;
      end else if (data_valid && !r_hold_full) begin
         r_hold      <= data_in;
         r_hold_full <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_tx_done <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
               if (w_load) begin
                  r_shift <= r_hold;
                  r_state <= ST_START;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            ST_START: begin
               if (w_tick) begin
                  r_state   <= ST_DATA;
                  r_bit_idx <= '0;
                  r_tx      <= r_shift[0];
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  r_shift   <= r_shift >> 1;
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == LAST_BIT) begin
                     r_state <= ST_STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     // Next bit is shift[1] before this edge's shift lands.
                     r_tx <= r_shift[1];
                  end
               end
            end
            ST_STOP: begin
               if (w_count == PRE_LAST) begin
                  r_tx_done <= 1'b1;
               end
               if (w_tick) begin
                  if (w_load) begin
                     r_shift <= r_hold;
                     r_state <= ST_START;
                     r_tx    <= 1'b0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data_ready = !r_hold_full;
   assign tx         = r_tx;
   assign busy       = r_busy;
   assign tx_done    = r_tx_done;

endmodule
